data_mem_responder: RTL

//  Multi-cycle data-memory responder serving the pipeline MEM stage's load/store requests.
//  The pipeline presents MemRead/MemWrite, a byte address and store data.

---
 rtl/data_mem_responder_pkg.sv | 27 ++
 rtl/data_mem_responder_dmem_array.sv | 37 +++
 rtl/data_mem_responder.sv | 123 ++++++++++++
 3 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the multi-cycle data-memory responder: word width,
// alignment mask, FSM state type and the request-validation helper.
package data_mem_responder_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam logic [1:0]  ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_WAIT = 2'd1,
    DM_DONE = 2'd2
  } dm_state_e;

  // A request is rejected when it is both a load and a store, is not
  // word aligned, or addresses a word beyond the array.
  function automatic logic dm_bad_req(
    input logic              rd,
    input logic              wr,
    input logic [WORD_W-1:0] a,
    input int unsigned       depth
  );
    logic [WORD_W-1:0] w_word;
    w_word = {2'b00, a[WORD_W-1:2]};
    return (rd & wr) | ((a[1:0] & ALIGN_MASK) != 2'b00) | (w_word >= depth);
  endfunction

endpackage

// File: rtl/data_mem_responder_dmem_array.sv
// Single-port DEPTH x 32 storage: synchronous write, registered read.
// Only the read register is reset; the contents are not.
module dmem_array
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [AW-1:0]     i_idx,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_re) begin
      r_q <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: validates requests,
// stalls the pipeline for LATENCY cycles, then performs the access.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic              stall,
  output logic [WORD_W-1:0] rdata,
  output logic              rvalid,
  output logic              err
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
  localparam logic        DIRECT   = (LATENCY == 1);

  dm_state_e         r_state;
  logic [3:0]        r_cnt;
  logic              r_op_rd;
  logic [AW-1:0]     r_idx;
  logic [WORD_W-1:0] r_wdata;
  logic              r_rvalid;
  logic              r_err;

  logic              w_req;
  logic              w_bad;
  logic              w_accept;
  logic              w_fire;
  logic              w_op_rd;
  logic [AW-1:0]     w_idx;
  logic [WORD_W-1:0] w_wdata;

  assign w_req    = mem_read | mem_write;
  assign w_bad    = dm_bad_req(mem_read, mem_write, addr, DEPTH);
  assign w_accept = (r_state == DM_IDLE) & w_req & ~w_bad;

  // The access fires on the edge that enters DONE. With LATENCY=1 that is
  // the accepting edge itself, so the live inputs bypass the latches.
  always_comb begin
    w_fire  = 1'b0;
    w_op_rd = r_op_rd;
    w_idx   = r_idx;
    w_wdata = r_wdata;
    if (r_state == DM_IDLE) begin
      w_op_rd = mem_read;
      w_idx   = addr[AW+1:2];
      w_wdata = wdata;
      w_fire  = w_accept & DIRECT;
    end else if (r_state == DM_WAIT) begin
      w_fire  = (r_cnt == 4'd1);
    end
    if (rst) begin
      w_fire = 1'b0;
    end
  end

  assign stall = ~rst & (w_accept | (r_state == DM_WAIT));

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .i_rst   (rst),
    .i_we    (w_fire & ~w_op_rd),
    .i_re    (w_fire & w_op_rd),
    .i_idx   (w_idx),
    .i_wdata (w_wdata),
    .o_rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= DM_IDLE;
      r_cnt    <= '0;
      r_op_rd  <= 1'b0;
      r_idx    <= '0;
      r_wdata  <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= w_fire & w_op_rd;
      r_err    <= 1'b0;
      case (r_state)
        DM_IDLE: begin
          if (w_req & w_bad) begin
            r_err <= 1'b1;
          end else if (w_accept) begin
            r_op_rd <= mem_read;
            r_idx   <= addr[AW+1:2];
            r_wdata <= wdata;
            r_cnt   <= CNT_INIT;
            r_state <= DIRECT ? DM_DONE : DM_WAIT;
          end
        end
        DM_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= DM_DONE;
          end
        end
        DM_DONE: begin
          r_state <= DM_IDLE;
        end
        default: begin
          r_state <= DM_IDLE;
        end
      endcase
    end
  end

  assign rvalid = r_rvalid;
  assign err    = r_err;

endmodule
